// File: rtl/change_dispenser_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : change_dispenser_if
//  Description : Request / status bundle between the vending FSM, the front
//                panel and the change dispenser.
//                Requests : R, N1, D1, D2, refill, refill_n, refill_d
//                Status   : release_p (paper-door release pulse), eject_n,
//                           eject_d, busy, exact_change, fault, overrun,
//                           nickel_cnt / dime_cnt (live hopper inventory)
//                "release" is a reserved word in SystemVerilog, so the
//                paper-door pulse is carried as release_p.
//  Revision    : 1.0 - initial release
// ============================================================================
interface change_dispenser_if #(
    parameter int INV_W = 6
) ();

    logic             R;
    logic             N1;
    logic             D1;
    logic             D2;
    logic             refill;
    logic [INV_W-1:0] refill_n;
    logic [INV_W-1:0] refill_d;

    logic             release_p;
    logic             eject_n;
    logic             eject_d;
    logic             busy;
    logic             exact_change;
    logic             fault;
    logic             overrun;
    logic [INV_W-1:0] nickel_cnt;
    logic [INV_W-1:0] dime_cnt;

    // Requester side (vending FSM / panel / testbench)
    modport master (
        output R, N1, D1, D2, refill, refill_n, refill_d,
        input  release_p, eject_n, eject_d, busy, exact_change, fault,
               overrun, nickel_cnt, dime_cnt
    );

    // Dispenser side
    modport slave (
        input  R, N1, D1, D2, refill, refill_n, refill_d,
        output release_p, eject_n, eject_d, busy, exact_change, fault,
               overrun, nickel_cnt, dime_cnt
    );

endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Paper-release and coin-ejector driver. Accepts a one-cycle
//                vend request (R with N1/D1/D2), pulses the paper door, then
//                fires the dime and nickel solenoids one coin at a time with
//                a fixed on-time and off-time. Tracks hopper inventory,
//                substitutes two nickels for a missing dime and flags
//                exact-change-only / shortage / lost-request conditions.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - change_dispenser_if.slave (requests in, status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int INV_W        = 6,
    parameter int NICKEL_INIT  = 20,
    parameter int DIME_INIT    = 20
) (
    input  wire logic          clk,
    input  wire logic          rst,
    change_dispenser_if.slave  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_REL     = 3'd1;
    localparam logic [2:0] c_ST_DIME_ON = 3'd2;
    localparam logic [2:0] c_ST_NICK_ON = 3'd3;
    localparam logic [2:0] c_ST_GAP     = 3'd4;

    // One timer serves both the on-time and the off-time phases.
    localparam int c_TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_TMR_W-1:0] c_PULSE_LAST = c_TMR_W'(PULSE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST   = c_TMR_W'(GAP_CYCLES - 1);
    localparam logic [INV_W-1:0]   c_N_INIT     = INV_W'(NICKEL_INIT);
    localparam logic [INV_W-1:0]   c_D_INIT     = INV_W'(DIME_INIT);
    localparam logic [INV_W-1:0]   c_N_LOW      = INV_W'(3);
    localparam logic [INV_W-1:0]   c_D_LOW      = INV_W'(2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]         r_state_q,  w_state_d;
    logic [c_TMR_W-1:0] r_tmr_q,    w_tmr_d;
    // Dimes owed: D1 + 2*D2 <= 3. Nickels owed: N1 plus two per converted
    // dime, so at most 1 + 2*3 = 7.
    logic [1:0]         r_dowed_q,  w_dowed_d;
    logic [2:0]         r_nowed_q,  w_nowed_d;
    logic [INV_W-1:0]   r_ninv_q,   w_ninv_d;
    logic [INV_W-1:0]   r_dinv_q,   w_dinv_d;
    // Single-entry pending request
    logic               r_pend_q,   w_pend_d;
    logic               r_pend_n_q, w_pend_n_d;
    logic [1:0]         r_pend_d_q, w_pend_d_d;
    logic               r_fault_q,  w_fault_d;
    logic               r_ovr_q,    w_ovr_d;

    // Per-cycle decision flags
    logic               w_select;     // choose the next coin slot this edge
    logic               w_start;      // enter REL this edge
    logic               w_from_pend;  // the request being started is the pending one
    logic [1:0]         w_req_dimes;

    assign w_req_dimes = {1'b0, bus.D1} + {bus.D2, 1'b0};

    // ------------------------------------------------------------------
    // Process 1: state register (asynchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= c_ST_IDLE;
            r_tmr_q    <= '0;
            r_dowed_q  <= '0;
            r_nowed_q  <= '0;
            r_ninv_q   <= c_N_INIT;
            r_dinv_q   <= c_D_INIT;
            r_pend_q   <= 1'b0;
            r_pend_n_q <= 1'b0;
            r_pend_d_q <= '0;
            r_fault_q  <= 1'b0;
            r_ovr_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_tmr_q    <= w_tmr_d;
            r_dowed_q  <= w_dowed_d;
            r_nowed_q  <= w_nowed_d;
            r_ninv_q   <= w_ninv_d;
            r_dinv_q   <= w_dinv_d;
            r_pend_q   <= w_pend_d;
            r_pend_n_q <= w_pend_n_d;
            r_pend_d_q <= w_pend_d_d;
            r_fault_q  <= w_fault_d;
            r_ovr_q    <= w_ovr_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_tmr_d     = r_tmr_q;
        w_dowed_d   = r_dowed_q;
        w_nowed_d   = r_nowed_q;
        w_ninv_d    = r_ninv_q;
        w_dinv_d    = r_dinv_q;
        w_pend_d    = r_pend_q;
        w_pend_n_d  = r_pend_n_q;
        w_pend_d_d  = r_pend_d_q;
        w_fault_d   = r_fault_q;
        w_ovr_d     = r_ovr_q;
        w_select    = 1'b0;
        w_start     = 1'b0;
        w_from_pend = 1'b0;

        case (r_state_q)
            c_ST_IDLE: begin
                // A pending request left behind by a shortage abort is
                // served first; otherwise a fresh request starts directly.
                if (r_pend_q) begin
                    w_start     = 1'b1;
                    w_from_pend = 1'b1;
                end else begin
                    if (bus.R) begin
                        w_start = 1'b1;
                    end
                    if (bus.refill) begin
                        w_ninv_d  = bus.refill_n;
                        w_dinv_d  = bus.refill_d;
                        w_fault_d = 1'b0;
                    end
                end
            end

            c_ST_REL: begin
                w_select = 1'b1;
            end

            c_ST_DIME_ON: begin
                if (r_tmr_q == c_PULSE_LAST) begin
                    // Coin counted as paid on its last on-cycle
                    if (r_dowed_q != '0) w_dowed_d = r_dowed_q - 2'd1;
                    if (r_dinv_q  != '0) w_dinv_d  = r_dinv_q - 1'b1;
                    w_tmr_d   = '0;
                    w_state_d = c_ST_GAP;
                end else begin
                    w_tmr_d = r_tmr_q + 1'b1;
                end
            end

            c_ST_NICK_ON: begin
                if (r_tmr_q == c_PULSE_LAST) begin
                    if (r_nowed_q != '0) w_nowed_d = r_nowed_q - 3'd1;
                    if (r_ninv_q  != '0) w_ninv_d  = r_ninv_q - 1'b1;
                    w_tmr_d   = '0;
                    w_state_d = c_ST_GAP;
                end else begin
                    w_tmr_d = r_tmr_q + 1'b1;
                end
            end

            c_ST_GAP: begin
                if (r_tmr_q == c_GAP_LAST) begin
                    w_select = 1'b1;
                end else begin
                    w_tmr_d = r_tmr_q + 1'b1;
                end
            end

            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase

        // Choose the next coin slot. Dimes go first; a dime slot with an
        // empty dime hopper turns into two nickels owed and the slot is
        // used for a nickel instead. An empty nickel hopper ends the
        // transaction with a shortage fault.
        if (w_select) begin
            w_tmr_d = '0;
            if (r_dowed_q != '0) begin
                if (r_dinv_q != '0) begin
                    w_state_d = c_ST_DIME_ON;
                end else begin
                    w_dowed_d = r_dowed_q - 2'd1;
                    w_nowed_d = r_nowed_q + 3'd2;
                    if (r_ninv_q != '0) begin
                        w_state_d = c_ST_NICK_ON;
                    end else begin
                        w_dowed_d = '0;
                        w_nowed_d = '0;
                        w_fault_d = 1'b1;
                        w_state_d = c_ST_IDLE;
                    end
                end
            end else if (r_nowed_q != '0) begin
                if (r_ninv_q != '0) begin
                    w_state_d = c_ST_NICK_ON;
                end else begin
                    w_nowed_d = '0;
                    w_fault_d = 1'b1;
                    w_state_d = c_ST_IDLE;
                end
            end else if (r_pend_q) begin
                // Back-to-back: pending request goes straight to REL
                w_start     = 1'b1;
                w_from_pend = 1'b1;
            end else begin
                w_state_d = c_ST_IDLE;
            end
        end

        if (w_start) begin
            w_state_d = c_ST_REL;
            w_tmr_d   = '0;
            if (w_from_pend) begin
                w_dowed_d = r_pend_d_q;
                w_nowed_d = {2'b00, r_pend_n_q};
                w_pend_d  = 1'b0;
            end else begin
                w_dowed_d = w_req_dimes;
                w_nowed_d = {2'b00, bus.N1};
            end
        end

        // A request that cannot start directly goes into the pending slot,
        // which is free if empty or being drained on this same edge.
        if (bus.R && !(r_state_q == c_ST_IDLE && !r_pend_q)) begin
            if (!r_pend_q || w_from_pend) begin
                w_pend_d   = 1'b1;
                w_pend_n_d = bus.N1;
                w_pend_d_d = w_req_dimes;
            end else begin
                w_ovr_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Process 3: outputs. Ejectors decode directly from the state flop so
    // an asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        bus.release_p    = (r_state_q == c_ST_REL);
        bus.eject_d      = (r_state_q == c_ST_DIME_ON);
        bus.eject_n      = (r_state_q == c_ST_NICK_ON);
        bus.busy         = (r_state_q != c_ST_IDLE);
        bus.exact_change = (r_ninv_q < c_N_LOW) || (r_dinv_q < c_D_LOW);
        bus.fault        = r_fault_q;
        bus.overrun      = r_ovr_q;
        bus.nickel_cnt   = r_ninv_q;
        bus.dime_cnt     = r_dinv_q;
    end

endmodule
`default_nettype wire
